// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer writeback controller.
// Entry fields are sized to the largest supported widths; narrower
// instances zero-extend on write and slice on read.
package rob_pkg;

  localparam int ROB_DATA_MAX = 64;  // upper bound for OPRAND_WIDTH
  localparam int ROB_REG_MAX  = 8;   // upper bound for REGNAME_WIDTH

  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic                    wr;
    logic [ROB_REG_MAX-1:0]  target;
    logic [ROB_DATA_MAX-1:0] data;
  } rob_entry_t;

  // Tag width for a power-of-two buffer depth.
  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_wb_ctrl_if.sv
// Enqueue / completion / flush / writeback bundle for rob_wb_ctrl.
// Parameters must match the ones given to the rob_wb_ctrl instance.
interface rob_wb_ctrl_if #(
  parameter int OPRAND_WIDTH  = 16,
  parameter int REGNAME_WIDTH = 5,
  parameter int ROB_ENTRY     = 16
);
  import rob_pkg::*;
  localparam int TAG_W = tag_w(ROB_ENTRY);

  logic                     enq1_en, enq2_en;
  logic [REGNAME_WIDTH-1:0] enq1_target, enq2_target;
  logic                     enq1_wr, enq2_wr;
  logic                     enq_ready;
  logic [TAG_W-1:0]         enq1_tag, enq2_tag;
  logic                     cmpl1_en, cmpl2_en;
  logic [TAG_W-1:0]         cmpl1_tag, cmpl2_tag;
  logic [OPRAND_WIDTH-1:0]  cmpl1_data, cmpl2_data;
  logic                     flush;
  logic                     WB_en1, WB_en2;
  logic [REGNAME_WIDTH-1:0] WB_target1, WB_target2;
  logic [OPRAND_WIDTH-1:0]  WB_data1, WB_data2;
  logic [TAG_W:0]           count;
  logic                     empty;

  modport master (
    output enq1_en, enq2_en, enq1_target, enq2_target, enq1_wr, enq2_wr,
           cmpl1_en, cmpl2_en, cmpl1_tag, cmpl2_tag, cmpl1_data, cmpl2_data, flush,
    input  enq_ready, enq1_tag, enq2_tag, WB_en1, WB_en2, WB_target1, WB_target2,
           WB_data1, WB_data2, count, empty
  );

  modport slave (
    input  enq1_en, enq2_en, enq1_target, enq2_target, enq1_wr, enq2_wr,
           cmpl1_en, cmpl2_en, cmpl1_tag, cmpl2_tag, cmpl1_data, cmpl2_data, flush,
    output enq_ready, enq1_tag, enq2_tag, WB_en1, WB_en2, WB_target1, WB_target2,
           WB_data1, WB_data2, count, empty
  );

endinterface

// File: rtl/rob_retire_sel.sv
// Picks which of head / head+1 retire this cycle.
// Macro ROB_CMPL_BYPASS_EN: a completion arriving this cycle for head or
// head+1 counts as done, and its data is forwarded to the writeback path.
module rob_retire_sel
  import rob_pkg::*;
`ifdef ROB_CMPL_BYPASS_EN
#(
  parameter int TAG_W = 4
)
`endif
(
  input  rob_entry_t              i_e0,
  input  rob_entry_t              i_e1,
`ifdef ROB_CMPL_BYPASS_EN
  input  logic [TAG_W-1:0]        i_head0,
  input  logic [TAG_W-1:0]        i_head1,
  input  logic                    i_cmpl1_en,
  input  logic [TAG_W-1:0]        i_cmpl1_tag,
  input  logic [ROB_DATA_MAX-1:0] i_cmpl1_data,
  input  logic                    i_cmpl2_en,
  input  logic [TAG_W-1:0]        i_cmpl2_tag,
  input  logic [ROB_DATA_MAX-1:0] i_cmpl2_data,
`endif
  output logic                    o_ret0,
  output logic                    o_ret1,
  output logic [ROB_DATA_MAX-1:0] o_data0,
  output logic [ROB_DATA_MAX-1:0] o_data1
);

  logic w_done0, w_done1;

  // Effective done/data per slot, then in-order retire with a same-target hazard stop.
  always_comb begin
    w_done0 = i_e0.done;
    w_done1 = i_e1.done;
    o_data0 = i_e0.data;
    o_data1 = i_e1.data;
`ifdef ROB_CMPL_BYPASS_EN
    // cmpl2 is checked last so it wins on a shared tag, matching the array write order
    if (i_cmpl1_en && i_cmpl1_tag == i_head0) begin w_done0 = 1'b1; o_data0 = i_cmpl1_data; end
    if (i_cmpl2_en && i_cmpl2_tag == i_head0) begin w_done0 = 1'b1; o_data0 = i_cmpl2_data; end
    if (i_cmpl1_en && i_cmpl1_tag == i_head1) begin w_done1 = 1'b1; o_data1 = i_cmpl1_data; end
    if (i_cmpl2_en && i_cmpl2_tag == i_head1) begin w_done1 = 1'b1; o_data1 = i_cmpl2_data; end
`endif
    o_ret0 = i_e0.valid & w_done0;
    // two writes to one register in a cycle would race in the regfile; defer the younger
    o_ret1 = o_ret0 & i_e1.valid & w_done1 &
             ~(i_e0.wr & i_e1.wr & (i_e0.target == i_e1.target));
  end

endmodule

// File: rtl/rob_wb_ctrl.sv
// Dual-issue reorder buffer: two enqueues, two completions and up to two
// in-order retirements per cycle, with registered register-file writeback.
// Optional macro ROB_CMPL_BYPASS_EN lets same-cycle completions retire.
module rob_wb_ctrl
  import rob_pkg::*;
#(
  parameter int OPRAND_WIDTH  = 16,
  parameter int REGNAME_WIDTH = 5,
  parameter int ROB_ENTRY     = 16
) (
  input logic          clk,
  input logic          rst,
  rob_wb_ctrl_if.slave bus
);

  localparam int             TAG_W = tag_w(ROB_ENTRY);
  localparam logic [TAG_W:0] DEPTH = (TAG_W+1)'(ROB_ENTRY);

  rob_entry_t               r_rob [ROB_ENTRY];
  logic [TAG_W-1:0]         r_head, r_tail;
  logic [TAG_W:0]           r_count;
  logic                     r_wb_en1, r_wb_en2;
  logic [REGNAME_WIDTH-1:0] r_wb_tgt1, r_wb_tgt2;
  logic [OPRAND_WIDTH-1:0]  r_wb_dat1, r_wb_dat2;

  logic [TAG_W-1:0]         w_head1, w_tail1;
  logic                     w_enq_ready, w_acc1, w_acc2, w_ret1, w_ret2;
  logic [ROB_DATA_MAX-1:0]  w_rdat1, w_rdat2;
  logic [TAG_W:0]           w_count_nxt;
  rob_entry_t               w_e0, w_e1;
  logic                     w_unused;

  assign w_head1     = r_head + TAG_W'(1);
  assign w_tail1     = r_tail + TAG_W'(1);
  assign w_e0        = r_rob[r_head];
  assign w_e1        = r_rob[w_head1];
  assign w_enq_ready = (DEPTH - r_count) >= (TAG_W+1)'(2);
  assign w_acc1      = w_enq_ready & bus.enq1_en;
  assign w_acc2      = w_acc1 & bus.enq2_en;   // slot 2 alone is meaningless
  assign w_count_nxt = r_count + (TAG_W+1)'(w_acc1) + (TAG_W+1)'(w_acc2)
                               - (TAG_W+1)'(w_ret1) - (TAG_W+1)'(w_ret2);
  // fields beyond the configured widths are always zero
  assign w_unused    = ^{w_e0, w_e1, w_rdat1, w_rdat2};

  rob_retire_sel
`ifdef ROB_CMPL_BYPASS_EN
    #(.TAG_W(TAG_W))
`endif
  u_sel (
    .i_e0         (w_e0),
    .i_e1         (w_e1),
`ifdef ROB_CMPL_BYPASS_EN
    .i_head0      (r_head),
    .i_head1      (w_head1),
    .i_cmpl1_en   (bus.cmpl1_en),
    .i_cmpl1_tag  (bus.cmpl1_tag),
    .i_cmpl1_data (ROB_DATA_MAX'(bus.cmpl1_data)),
    .i_cmpl2_en   (bus.cmpl2_en),
    .i_cmpl2_tag  (bus.cmpl2_tag),
    .i_cmpl2_data (ROB_DATA_MAX'(bus.cmpl2_data)),
`endif
    .o_ret0       (w_ret1),
    .o_ret1       (w_ret2),
    .o_data0      (w_rdat1),
    .o_data1      (w_rdat2)
  );

  // Buffer state: reset/flush wipe everything; otherwise complete, retire, enqueue.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROB_ENTRY; i++) begin
        r_rob[i].valid <= 1'b0;
        r_rob[i].done  <= 1'b0;
      end
    end else begin
      if (bus.cmpl1_en && r_rob[bus.cmpl1_tag].valid) begin
        r_rob[bus.cmpl1_tag].done <= 1'b1;
        r_rob[bus.cmpl1_tag].data <= ROB_DATA_MAX'(bus.cmpl1_data);
      end
      if (bus.cmpl2_en && r_rob[bus.cmpl2_tag].valid) begin
        r_rob[bus.cmpl2_tag].done <= 1'b1;
        r_rob[bus.cmpl2_tag].data <= ROB_DATA_MAX'(bus.cmpl2_data);
      end
      // retiring entries are valid, enqueue slots are free: no index overlap
      if (w_ret1) begin r_rob[r_head].valid  <= 1'b0; r_rob[r_head].done  <= 1'b0; end
      if (w_ret2) begin r_rob[w_head1].valid <= 1'b0; r_rob[w_head1].done <= 1'b0; end
      if (w_acc1)
        r_rob[r_tail]  <= '{valid: 1'b1, done: 1'b0, wr: bus.enq1_wr,
                            target: ROB_REG_MAX'(bus.enq1_target), data: '0};
      if (w_acc2)
        r_rob[w_tail1] <= '{valid: 1'b1, done: 1'b0, wr: bus.enq2_wr,
                            target: ROB_REG_MAX'(bus.enq2_target), data: '0};
      r_head  <= r_head + TAG_W'(w_ret1) + TAG_W'(w_ret2);
      r_tail  <= r_tail + TAG_W'(w_acc1) + TAG_W'(w_acc2);
      r_count <= w_count_nxt;
    end
  end

  // Writeback register: one cycle after the retire decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_en1  <= 1'b0;
      r_wb_en2  <= 1'b0;
      r_wb_tgt1 <= '0;
      r_wb_tgt2 <= '0;
      r_wb_dat1 <= '0;
      r_wb_dat2 <= '0;
    end else if (bus.flush) begin
      r_wb_en1  <= 1'b0;
      r_wb_en2  <= 1'b0;
    end else begin
      r_wb_en1  <= w_ret1 & w_e0.wr;
      r_wb_en2  <= w_ret2 & w_e1.wr;
      r_wb_tgt1 <= w_e0.target[REGNAME_WIDTH-1:0];
      r_wb_tgt2 <= w_e1.target[REGNAME_WIDTH-1:0];
      r_wb_dat1 <= w_rdat1[OPRAND_WIDTH-1:0];
      r_wb_dat2 <= w_rdat2[OPRAND_WIDTH-1:0];
    end
  end

  assign bus.enq_ready  = w_enq_ready;
  assign bus.enq1_tag   = r_tail;
  assign bus.enq2_tag   = w_tail1;
  assign bus.WB_en1     = r_wb_en1;
  assign bus.WB_en2     = r_wb_en2;
  assign bus.WB_target1 = r_wb_tgt1;
  assign bus.WB_target2 = r_wb_tgt2;
  assign bus.WB_data1   = r_wb_dat1;
  assign bus.WB_data2   = r_wb_dat2;
  assign bus.count      = r_count;
  assign bus.empty      = (r_count == '0);

endmodule

// File: tb/tb_rob_wb_ctrl.sv
// Directed bench for rob_wb_ctrl (ROB_ENTRY=16, 16-bit data, 5-bit regs).
// Expected writeback latency depends on ROB_CMPL_BYPASS_EN.
module tb_rob_wb_ctrl;

  localparam int OW = 16, RW = 5, RE = 16;
`ifdef ROB_CMPL_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  rob_wb_ctrl_if #(.OPRAND_WIDTH(OW), .REGNAME_WIDTH(RW), .ROB_ENTRY(RE)) bus ();

  rob_wb_ctrl #(.OPRAND_WIDTH(OW), .REGNAME_WIDTH(RW), .ROB_ENTRY(RE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.enq1_en = 0; bus.enq2_en = 0; bus.enq1_target = '0; bus.enq2_target = '0;
    bus.enq1_wr = 0; bus.enq2_wr = 0; bus.cmpl1_en = 0; bus.cmpl2_en = 0;
    bus.cmpl1_tag = '0; bus.cmpl2_tag = '0; bus.cmpl1_data = '0; bus.cmpl2_data = '0;
    bus.flush = 0;
  endtask

  task automatic do_rst;
    idle; rst = 1; tick; rst = 0;
  endtask

  task automatic enq(input logic e1, input logic [4:0] t1, input logic w1,
                     input logic e2, input logic [4:0] t2, input logic w2);
    bus.enq1_en = e1; bus.enq1_target = t1; bus.enq1_wr = w1;
    bus.enq2_en = e2; bus.enq2_target = t2; bus.enq2_wr = w2;
  endtask

  task automatic cmpl(input logic e1, input logic [3:0] g1, input logic [15:0] d1,
                      input logic e2, input logic [3:0] g2, input logic [15:0] d2);
    bus.cmpl1_en = e1; bus.cmpl1_tag = g1; bus.cmpl1_data = d1;
    bus.cmpl2_en = e2; bus.cmpl2_tag = g2; bus.cmpl2_data = d2;
  endtask

  // rst asserted while a retirement is in flight must leave everything clean
  task automatic test_reset;
    do_rst;
    enq(1, 5'd3, 1, 0, 5'd0, 0); tick; idle;
    cmpl(1, 4'd0, 16'h5555, 0, 4'd0, 16'h0); tick; idle;
    rst = 1; tick; rst = 0;
    vecs++; if (bus.count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    vecs++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    vecs++; if (bus.enq_ready !== 1'b1) begin errs++; $display("FAIL reset_enq_ready got %b exp 1", bus.enq_ready); end
    vecs++; if (bus.WB_en1 !== 1'b0 || bus.WB_en2 !== 1'b0) begin errs++; $display("FAIL reset_wb_en got %b%b exp 00", bus.WB_en1, bus.WB_en2); end
    vecs++; if (bus.WB_target1 !== 5'd0 || bus.WB_data1 !== 16'h0) begin errs++; $display("FAIL reset_wb_bus got t%0d d%h exp t0 d0000", bus.WB_target1, bus.WB_data1); end
    vecs++; if (bus.enq1_tag !== 4'd0 || bus.enq2_tag !== 4'd1) begin errs++; $display("FAIL reset_tags got %0d/%0d exp 0/1", bus.enq1_tag, bus.enq2_tag); end
    tick;
    vecs++; if (bus.WB_en1 !== 1'b0) begin errs++; $display("FAIL reset_stale_wb got %b exp 0", bus.WB_en1); end
  endtask

  // one entry: checks tag, count and completion-to-writeback latency
  task automatic test_single;
    do_rst;
    enq(1, 5'd3, 1, 0, 5'd0, 0);
    vecs++; if (bus.enq1_tag !== 4'd0) begin errs++; $display("FAIL single_tag got %0d exp 0", bus.enq1_tag); end
    tick; idle;
    vecs++; if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin errs++; $display("FAIL single_count got %0d/%b exp 1/0", bus.count, bus.empty); end
    cmpl(1, 4'd0, 16'h1234, 0, 4'd0, 16'h0); tick; idle;
    vecs++; if (bus.WB_en1 !== (LAT == 1)) begin errs++; $display("FAIL latency_n1 got %b exp %b", bus.WB_en1, (LAT == 1)); end
    repeat (LAT - 1) tick;
    vecs++; if (bus.WB_en1 !== 1'b1 || bus.WB_target1 !== 5'd3 || bus.WB_data1 !== 16'h1234) begin errs++; $display("FAIL single_wb got %b t%0d d%h exp 1 t3 d1234", bus.WB_en1, bus.WB_target1, bus.WB_data1); end
    vecs++; if (bus.WB_en2 !== 1'b0) begin errs++; $display("FAIL single_wb2 got %b exp 0", bus.WB_en2); end
    vecs++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin errs++; $display("FAIL single_drain got %0d/%b exp 0/1", bus.count, bus.empty); end
    tick;
    vecs++; if (bus.WB_en1 !== 1'b0) begin errs++; $display("FAIL single_wb_drop got %b exp 0", bus.WB_en1); end
  endtask

  // younger completes first: nothing retires until the head is done
  task automatic test_in_order;
    do_rst;
    enq(1, 5'd1, 1, 1, 5'd2, 1);
    vecs++; if (bus.enq1_tag !== 4'd0 || bus.enq2_tag !== 4'd1) begin errs++; $display("FAIL order_tags got %0d/%0d exp 0/1", bus.enq1_tag, bus.enq2_tag); end
    tick; idle;
    vecs++; if (bus.count !== 5'd2) begin errs++; $display("FAIL order_count got %0d exp 2", bus.count); end
    cmpl(1, 4'd1, 16'h0B0B, 0, 4'd0, 16'h0); tick; idle;
    vecs++; if (bus.WB_en1 !== 1'b0 || bus.WB_en2 !== 1'b0) begin errs++; $display("FAIL order_hold1 got %b%b exp 00", bus.WB_en1, bus.WB_en2); end
    tick;
    vecs++; if (bus.WB_en1 !== 1'b0 || bus.WB_en2 !== 1'b0) begin errs++; $display("FAIL order_hold2 got %b%b exp 00", bus.WB_en1, bus.WB_en2); end
    cmpl(1, 4'd0, 16'h0A0A, 0, 4'd0, 16'h0); tick; idle;
    vecs++; if (bus.WB_en1 !== (LAT == 1)) begin errs++; $display("FAIL order_latency got %b exp %b", bus.WB_en1, (LAT == 1)); end
    repeat (LAT - 1) tick;
    vecs++; if (bus.WB_en1 !== 1'b1 || bus.WB_target1 !== 5'd1 || bus.WB_data1 !== 16'h0A0A) begin errs++; $display("FAIL order_wb1 got %b t%0d d%h exp 1 t1 d0a0a", bus.WB_en1, bus.WB_target1, bus.WB_data1); end
    vecs++; if (bus.WB_en2 !== 1'b1 || bus.WB_target2 !== 5'd2 || bus.WB_data2 !== 16'h0B0B) begin errs++; $display("FAIL order_wb2 got %b t%0d d%h exp 1 t2 d0b0b", bus.WB_en2, bus.WB_target2, bus.WB_data2); end
    vecs++; if (bus.count !== 5'd0) begin errs++; $display("FAIL order_drain got %0d exp 0", bus.count); end
  endtask

  // both retiring entries write r5: serialised over two cycles on port 1
  task automatic test_same_target;
    do_rst;
    enq(1, 5'd5, 1, 1, 5'd5, 1); tick; idle;
    cmpl(1, 4'd0, 16'hAAAA, 1, 4'd1, 16'hBBBB); tick; idle;
    repeat (LAT - 1) tick;
    vecs++; if (bus.WB_en1 !== 1'b1 || bus.WB_target1 !== 5'd5 || bus.WB_data1 !== 16'hAAAA) begin errs++; $display("FAIL same_tgt_first got %b t%0d d%h exp 1 t5 daaaa", bus.WB_en1, bus.WB_target1, bus.WB_data1); end
    vecs++; if (bus.WB_en2 !== 1'b0 || bus.count !== 5'd1) begin errs++; $display("FAIL same_tgt_first_p2 got %b c%0d exp 0 c1", bus.WB_en2, bus.count); end
    tick;
    vecs++; if (bus.WB_en1 !== 1'b1 || bus.WB_target1 !== 5'd5 || bus.WB_data1 !== 16'hBBBB) begin errs++; $display("FAIL same_tgt_second got %b t%0d d%h exp 1 t5 dbbbb", bus.WB_en1, bus.WB_target1, bus.WB_data1); end
    vecs++; if (bus.WB_en2 !== 1'b0 || bus.count !== 5'd0) begin errs++; $display("FAIL same_tgt_second_p2 got %b c%0d exp 0 c0", bus.WB_en2, bus.count); end
    tick;
    vecs++; if (bus.WB_en1 !== 1'b0) begin errs++; $display("FAIL same_tgt_idle got %b exp 0", bus.WB_en1); end
  endtask

  // cmpl2 wins a shared tag; non-writing entries retire without WB_en
  task automatic test_cmpl_rules;
    do_rst;
    enq(1, 5'd7, 1, 0, 5'd0, 0); tick; idle;
    cmpl(1, 4'd0, 16'h1111, 1, 4'd0, 16'h2222); tick; idle;
    repeat (LAT - 1) tick;
    vecs++; if (bus.WB_en1 !== 1'b1 || bus.WB_target1 !== 5'd7 || bus.WB_data1 !== 16'h2222) begin errs++; $display("FAIL cmpl2_wins got %b t%0d d%h exp 1 t7 d2222", bus.WB_en1, bus.WB_target1, bus.WB_data1); end
    do_rst;
    enq(1, 5'd4, 0, 1, 5'd6, 1); tick; idle;
    cmpl(1, 4'd0, 16'h4444, 1, 4'd1, 16'h6666); tick; idle;
    repeat (LAT - 1) tick;
    vecs++; if (bus.WB_en1 !== 1'b0) begin errs++; $display("FAIL nowr_p1 got %b exp 0", bus.WB_en1); end
    vecs++; if (bus.WB_en2 !== 1'b1 || bus.WB_target2 !== 5'd6 || bus.WB_data2 !== 16'h6666) begin errs++; $display("FAIL nowr_p2 got %b t%0d d%h exp 1 t6 d6666", bus.WB_en2, bus.WB_target2, bus.WB_data2); end
    vecs++; if (bus.count !== 5'd0) begin errs++; $display("FAIL nowr_drain got %0d exp 0", bus.count); end
  endtask

  // enq_ready threshold, then 41 enqueues so tail and head wrap 15 -> 0
  task automatic test_fill_wrap;
    int exp_tail;
    int n;
    do_rst;
    for (int i = 0; i < 7; i++) begin
      vecs++; if (bus.enq1_tag !== 4'(2*i) || bus.enq2_tag !== 4'(2*i+1)) begin errs++; $display("FAIL fill_tags[%0d] got %0d/%0d exp %0d/%0d", i, bus.enq1_tag, bus.enq2_tag, 2*i, 2*i+1); end
      enq(1, 5'd0, 0, 1, 5'd0, 0); tick; idle;
    end
    vecs++; if (bus.count !== 5'd14 || bus.enq_ready !== 1'b1) begin errs++; $display("FAIL fill_14 got c%0d r%b exp c14 r1", bus.count, bus.enq_ready); end
    enq(1, 5'd0, 0, 0, 5'd0, 0); tick; idle;
    vecs++; if (bus.count !== 5'd15 || bus.enq_ready !== 1'b0) begin errs++; $display("FAIL fill_15 got c%0d r%b exp c15 r0", bus.count, bus.enq_ready); end
    enq(1, 5'd0, 0, 1, 5'd0, 0); tick; idle;
    vecs++; if (bus.count !== 5'd15 || bus.enq1_tag !== 4'd15) begin errs++; $display("FAIL fill_blocked got c%0d t%0d exp c15 t15", bus.count, bus.enq1_tag); end

    do_rst;
    exp_tail = 0;
    for (int it = 0; it < 21; it++) begin
      n = (it == 0) ? 1 : 2;
      vecs++; if (bus.enq1_tag !== 4'(exp_tail) || bus.enq2_tag !== 4'(exp_tail+1)) begin errs++; $display("FAIL wrap_tags[%0d] got %0d/%0d exp %0d/%0d", it, bus.enq1_tag, bus.enq2_tag, exp_tail%16, (exp_tail+1)%16); end
      enq(1, 5'(2*it), 1, (n == 2), 5'(2*it+1), 1); tick; idle;
      vecs++; if (bus.count !== 5'(n)) begin errs++; $display("FAIL wrap_count[%0d] got %0d exp %0d", it, bus.count, n); end
      cmpl(1, 4'(exp_tail), 16'(16'h100 + it), (n == 2), 4'(exp_tail+1), 16'(16'h200 + it)); tick; idle;
      repeat (LAT - 1) tick;
      vecs++; if (bus.WB_en1 !== 1'b1 || bus.WB_target1 !== 5'(2*it) || bus.WB_data1 !== 16'(16'h100 + it)) begin errs++; $display("FAIL wrap_wb1[%0d] got %b t%0d d%h exp 1 t%0d d%h", it, bus.WB_en1, bus.WB_target1, bus.WB_data1, 2*it, 16'h100 + it); end
      vecs++; if (bus.WB_en2 !== (n == 2) || (n == 2 && bus.WB_data2 !== 16'(16'h200 + it))) begin errs++; $display("FAIL wrap_wb2[%0d] got %b d%h exp %b d%h", it, bus.WB_en2, bus.WB_data2, (n == 2), 16'h200 + it); end
      vecs++; if (bus.count !== 5'd0) begin errs++; $display("FAIL wrap_drain[%0d] got %0d exp 0", it, bus.count); end
      exp_tail += n;
    end
  endtask

  // flush overrides same-cycle enqueue/completion; stale tags stay dead
  task automatic test_flush;
    do_rst;
    for (int i = 0; i < 3; i++) begin
      enq(1, 5'(10+2*i), 1, 1, 5'(11+2*i), 1); tick; idle;
    end
    cmpl(1, 4'd1, 16'h0001, 1, 4'd3, 16'h0003); tick; idle;
    cmpl(1, 4'd5, 16'h0005, 0, 4'd0, 16'h0); tick; idle;
    vecs++; if (bus.count !== 5'd6 || bus.WB_en1 !== 1'b0) begin errs++; $display("FAIL preflush got c%0d w%b exp c6 w0", bus.count, bus.WB_en1); end
    bus.flush = 1;
    cmpl(1, 4'd0, 16'hDEAD, 1, 4'd2, 16'hBEEF);
    enq(1, 5'd20, 1, 1, 5'd21, 1);
    tick; idle;
    vecs++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin errs++; $display("FAIL flush_count got c%0d e%b exp c0 e1", bus.count, bus.empty); end
    vecs++; if (bus.WB_en1 !== 1'b0 || bus.WB_en2 !== 1'b0) begin errs++; $display("FAIL flush_wb got %b%b exp 00", bus.WB_en1, bus.WB_en2); end
    vecs++; if (bus.enq1_tag !== 4'd0 || bus.enq_ready !== 1'b1) begin errs++; $display("FAIL flush_tail got t%0d r%b exp t0 r1", bus.enq1_tag, bus.enq_ready); end
    tick;
    vecs++; if (bus.WB_en1 !== 1'b0 || bus.WB_en2 !== 1'b0) begin errs++; $display("FAIL flush_wb_late got %b%b exp 00", bus.WB_en1, bus.WB_en2); end
    cmpl(1, 4'd1, 16'h7777, 0, 4'd0, 16'h0); tick; idle;
    vecs++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin errs++; $display("FAIL flush_stale_cmpl got c%0d e%b exp c0 e1", bus.count, bus.empty); end
    enq(1, 5'd9, 1, 0, 5'd0, 0); tick; idle;
    repeat (3) tick;
    vecs++; if (bus.WB_en1 !== 1'b0 || bus.count !== 5'd1) begin errs++; $display("FAIL flush_done_cleared got w%b c%0d exp w0 c1", bus.WB_en1, bus.count); end
    cmpl(1, 4'd0, 16'h0909, 0, 4'd0, 16'h0); tick; idle;
    repeat (LAT - 1) tick;
    vecs++; if (bus.WB_en1 !== 1'b1 || bus.WB_target1 !== 5'd9 || bus.WB_data1 !== 16'h0909) begin errs++; $display("FAIL flush_reuse got %b t%0d d%h exp 1 t9 d0909", bus.WB_en1, bus.WB_target1, bus.WB_data1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle;
    tick;
    test_reset;
    test_single;
    test_in_order;
    test_same_target;
    test_cmpl_rules;
    test_fill_wrap;
    test_flush;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
